// File: rtl/text_layer_pkg.sv
// Shared types and constants for the character-cell text overlay.
// Holds the palette, the cell attribute layout, the clear FSM states and the 8x8 glyph ROM.
package text_layer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Cell word layout: {glyph, fg[2:0], bg[2:0], blink, opaque}
    localparam int ATTR_OPAQUE = 0;
    localparam int ATTR_BLINK  = 1;
    localparam int ATTR_BG_LSB = 2;
    localparam int ATTR_FG_LSB = 5;
    localparam int ATTR_W      = 8;

    // 3-bit colour index {R,G,B} expanded to RGB888
    localparam logic [23:0] PALETTE [8] = '{
        24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
        24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
    };

    // Glyph ROM, one bit per lookup; sub_x=0 is the leftmost pixel (MSB of the row byte).
    function automatic logic glyph_bit(input logic [7:0] glyph,
                                       input logic [2:0] sub_y,
                                       input logic [2:0] sub_x);
        logic [7:0] row_bits;
        row_bits = 8'h00;
        case (glyph)
            8'd0: row_bits = 8'h00;
            8'd1: begin
                case (sub_y)
                    3'd0: row_bits = 8'h18;
                    3'd1: row_bits = 8'h3C;
                    3'd2: row_bits = 8'h66;
                    3'd3: row_bits = 8'h66;
                    3'd4: row_bits = 8'h7E;
                    3'd5: row_bits = 8'h66;
                    3'd6: row_bits = 8'h66;
                    default: row_bits = 8'h00;
                endcase
            end
            8'd2: row_bits = 8'hFF;
            default: row_bits = sub_y[0] ? 8'hAA : 8'h55;
        endcase
        return row_bits[3'd7 - sub_x];
    endfunction

endpackage

// File: rtl/text_cell_ram.sv
// Cell RAM: one write port, one registered read port.
// A read and write of the same cell in one cycle returns the old contents.
module text_cell_ram #(
    parameter int DEPTH  = 1200,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Out-of-range write addresses are dropped rather than aliased.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_layer.sv
// Character-cell text overlay: pixel -> cell RAM -> glyph ROM -> RGB888 with obj_on.
// Three-stage render pipeline plus a host write port shared with a clear-screen sweep.
module text_layer
    import text_layer_pkg::*;
#(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int CELL_W_LOG2  = 3,
    parameter int CELL_H_LOG2  = 3,
    parameter int GLYPH_BITS   = 4,
    parameter int X_W          = 9,
    parameter int Y_W          = 8,
    parameter int BLINK_FRAMES = 30,
    localparam int ADDR_W      = $clog2(COLS * ROWS),
    localparam int CELL_BITS   = GLYPH_BITS + 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [X_W-1:0]       pixel_x,
    input  logic [Y_W-1:0]       pixel_y,
    input  logic                 frame_start,
    input  logic                 toggle_en,
    input  logic                 cursor_en,
    input  logic [ADDR_W-1:0]    cursor_col,
    input  logic [ADDR_W-1:0]    cursor_row,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [CELL_BITS-1:0] wr_data,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic [7:0]           pixel_r,
    output logic [7:0]           pixel_g,
    output logic [7:0]           pixel_b,
    output logic                 obj_on,
    output clr_state_e           dbg_state_o
);

    localparam int DEPTH   = COLS * ROWS;
    localparam int COL_W   = X_W - CELL_W_LOG2;
    localparam int ROW_W   = Y_W - CELL_H_LOG2;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    // Write handshake: a write transfers on a clock edge where wr_valid && wr_ready;
    // wr_ready is high only while the clear sweep is idle.

    clr_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;
    logic                  layer_en_q;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  blink_ph_q, blink_ph_d;

    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [CELL_BITS-1:0]  ram_wdata;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [CELL_BITS-1:0]  cell_s1;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_data;
        case (state_q)
            IDLE: begin
                ram_we = wr_valid;
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = '0;
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_start) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            layer_en_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            layer_en_q  <= layer_en_q ^ toggle_en;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign wr_ready    = (state_q == IDLE);
    assign clr_busy    = (state_q == CLEAR);
    assign dbg_state_o = state_q;

    // S0: cell lookup
    logic [COL_W-1:0] col_s0;
    logic [ROW_W-1:0] row_s0;
    logic             in_area_s0;
    logic             cur_s0;

    assign col_s0     = pixel_x[X_W-1:CELL_W_LOG2];
    assign row_s0     = pixel_y[Y_W-1:CELL_H_LOG2];
    assign in_area_s0 = (int'(col_s0) < COLS) && (int'(row_s0) < ROWS);
    assign ram_raddr  = in_area_s0 ? ADDR_W'(int'(row_s0) * COLS + int'(col_s0)) : '0;
    // Range checks keep an out-of-range cursor from ever matching.
    assign cur_s0     = (cursor_col == ADDR_W'(col_s0)) && (cursor_row == ADDR_W'(row_s0)) &&
                        (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS);

    text_cell_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(CELL_BITS)
    ) u_cell_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(ram_raddr),
        .rdata_o(cell_s1)
    );

    // S1: glyph ROM lookup
    logic                   in_area_s1_q, en_s1_q, cur_s1_q;
    logic [CELL_W_LOG2-1:0] sub_x_s1_q;
    logic [CELL_H_LOG2-1:0] sub_y_s1_q;
    logic                   rom_bit_s1;

    assign rom_bit_s1 = glyph_bit(8'(cell_s1[CELL_BITS-1:ATTR_W]), 3'(sub_y_s1_q), 3'(sub_x_s1_q));

    // S2: colour resolve
    logic                   in_area_s2_q, en_s2_q, cur_s2_q, rom_bit_s2_q;
    logic [ATTR_W-1:0]      attr_s2_q;
    logic                   pix_bit;
    logic [23:0]            rgb_d, rgb_q;
    logic                   obj_d, obj_q;

    always_comb begin
        pix_bit = rom_bit_s2_q ^ (cur_s2_q & cursor_en & blink_ph_q);
        if (attr_s2_q[ATTR_BLINK] && blink_ph_q) begin
            pix_bit = 1'b0;
        end
        rgb_d = 24'h0;
        obj_d = 1'b0;
        if (en_s2_q && in_area_s2_q) begin
            if (pix_bit) begin
                rgb_d = PALETTE[attr_s2_q[ATTR_FG_LSB +: 3]];
                obj_d = 1'b1;
            end else if (attr_s2_q[ATTR_OPAQUE]) begin
                rgb_d = PALETTE[attr_s2_q[ATTR_BG_LSB +: 3]];
                obj_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_area_s1_q <= 1'b0;
            en_s1_q      <= 1'b0;
            cur_s1_q     <= 1'b0;
            sub_x_s1_q   <= '0;
            sub_y_s1_q   <= '0;
            in_area_s2_q <= 1'b0;
            en_s2_q      <= 1'b0;
            cur_s2_q     <= 1'b0;
            rom_bit_s2_q <= 1'b0;
            attr_s2_q    <= '0;
            rgb_q        <= 24'h0;
            obj_q        <= 1'b0;
        end else begin
            in_area_s1_q <= in_area_s0;
            en_s1_q      <= layer_en_q;
            cur_s1_q     <= cur_s0;
            sub_x_s1_q   <= pixel_x[CELL_W_LOG2-1:0];
            sub_y_s1_q   <= pixel_y[CELL_H_LOG2-1:0];
            in_area_s2_q <= in_area_s1_q;
            en_s2_q      <= en_s1_q;
            cur_s2_q     <= cur_s1_q;
            rom_bit_s2_q <= rom_bit_s1;
            attr_s2_q    <= cell_s1[ATTR_W-1:0];
            rgb_q        <= rgb_d;
            obj_q        <= obj_d;
        end
    end

    assign pixel_r = rgb_q[23:16];
    assign pixel_g = rgb_q[15:8];
    assign pixel_b = rgb_q[7:0];
    assign obj_on  = obj_q;

endmodule
